cmd_encod_linear_rw: RTL and testbench

//  Parametrised linear-access command-sequence encoder for the DDR3 sequencer: one start produces ACTIVATE,
//  N read or write bursts on consecutive columns of one row/bank, PRECHARGE and a done-tagged pause word.

---
 rtl/x393_mcntrl_pkg.sv | 43 ++++
 rtl/cmd_encod_linear_rw.sv | 130 +++++++++++++
 tb/tb_cmd_encod_linear_rw.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/x393_mcntrl_pkg.sv
// Shared sequencer command-word definitions: rcw codes, FSM states, flag bundle
// and the encoders that pack the 32-bit command memory word.
package x393_mcntrl_pkg;

  localparam logic [2:0] RCW_NOP       = 3'd0;
  localparam logic [2:0] RCW_READ      = 3'd2;
  localparam logic [2:0] RCW_WRITE     = 3'd3;
  localparam logic [2:0] RCW_ACTIVATE  = 3'd4;
  localparam logic [2:0] RCW_PRECHARGE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACT, ST_GAP, ST_BURST, ST_TAIL, ST_PRE, ST_PREW, ST_FIN
  } lin_state_t;

  typedef struct packed {
    logic odt;
    logic sel;
    logic dq_en;
    logic dqs_en;
    logic dqs_toggle;
    logic dci;
    logic buf_wr;
    logic buf_rd;
  } cmd_flags_t;

  // {addr[14:0],bank,rcw,odt,cke,sel,dq_en,dqs_en,dqs_toggle,dci,buf_wr,buf_rd,nop,0}
  function automatic logic [31:0] func_encode_cmd(input logic [14:0] addr, input logic [2:0] bank,
                                                  input logic [2:0] rcw, input cmd_flags_t f,
                                                  input logic nop);
    return {addr, bank, rcw, f.odt, 1'b0, f.sel, f.dq_en, f.dqs_en, f.dqs_toggle,
            f.dci, f.buf_wr, f.buf_rd, nop, 1'b0};
  endfunction

  // NOP/pause word: skip count in the low pause_bits, done flag at done_bit
  function automatic logic [31:0] func_encode_skip(input int pause_bits, input int done_bit,
                                                   input logic [14:0] skip, input logic done,
                                                   input logic [2:0] bank, input cmd_flags_t f);
    logic [14:0] a;
    a = (skip & ((15'd1 << pause_bits) - 15'd1)) | ({14'd0, done} << done_bit);
    return func_encode_cmd(a, bank, RCW_NOP, f, 1'b1);
  endfunction

endpackage

// File: rtl/cmd_encod_linear_rw.sv
// Linear read/write command-sequence encoder: ACTIVATE, N bursts on consecutive
// columns, PRECHARGE, done-tagged pause. Words are registered from the next state.
module cmd_encod_linear_rw
  import x393_mcntrl_pkg::*;
#(
  parameter int ADDRESS_NUMBER = 15,
  parameter int COLADDR_NUMBER = 10,
  parameter int NUM_XFER_BITS  = 6,
  parameter int CMD_PAUSE_BITS = 10,
  parameter int CMD_DONE_BIT   = 10,
  parameter bit WSEL           = 1'b1,
  parameter bit RSEL           = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                bank_in,
  input  logic [ADDRESS_NUMBER-1:0] row_in,
  input  logic [COLADDR_NUMBER-1:0] start_col,
  input  logic [NUM_XFER_BITS-1:0]  num128_in,
  input  logic                      start_rd,
  input  logic                      start_wr,
  output logic [31:0]               enc_cmd,
  output logic                      enc_wr,
  output logic                      enc_done,
  output logic                      busy
);

  lin_state_t                state, state_nxt;
  logic [2:0]                bank_r;
  logic [COLADDR_NUMBER-1:0] col_r;
  logic [NUM_XFER_BITS:0]    cnt_r;
  logic                      wr_mode;
  logic                      start;
  logic [31:0]               word_nxt;

  assign start = (state == ST_IDLE) && (start_rd || start_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ACT;
      ST_ACT:   state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_BURST;
      ST_BURST: if (cnt_r == '0) state_nxt = ST_TAIL;
      ST_TAIL:  state_nxt = ST_PRE;
      ST_PRE:   state_nxt = ST_PREW;
      ST_PREW:  state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // col_r/cnt_r always describe the next burst word to be emitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_r  <= '0;
      col_r   <= '0;
      cnt_r   <= '0;
      wr_mode <= 1'b0;
    end else if (start) begin
      bank_r  <= bank_in;
      col_r   <= start_col & ~COLADDR_NUMBER'(7);
      cnt_r   <= (num128_in == '0) ? {1'b1, {NUM_XFER_BITS{1'b0}}} : {1'b0, num128_in};
      wr_mode <= start_wr;
    end else if (state_nxt == ST_BURST) begin
      col_r <= col_r + COLADDR_NUMBER'(8);
      cnt_r <= cnt_r - (NUM_XFER_BITS+1)'(1);
    end
  end

  // Word for the state being entered; ACT is entered straight from IDLE,
  // so it takes row/bank from the inputs rather than the latches.
  always_comb begin
    logic [14:0] row_addr;
    logic [14:0] col_addr;
    cmd_flags_t  f;
    row_addr = '0;
    row_addr[ADDRESS_NUMBER-1:0] = row_in;
    col_addr = '0;
    col_addr[COLADDR_NUMBER-1:0] = col_r;
    f = '0;
    word_nxt = '0;
    case (state_nxt)
      ST_ACT:   word_nxt = func_encode_cmd(row_addr, bank_in, RCW_ACTIVATE, f, 1'b1);
      ST_GAP: begin
        f.buf_rd = wr_mode;
        word_nxt = func_encode_skip(CMD_PAUSE_BITS, CMD_DONE_BIT, 15'd1, 1'b0, bank_r, f);
      end
      ST_BURST: begin
        if (wr_mode) begin
          f.sel = WSEL; f.odt = 1'b1; f.buf_rd = 1'b1;
          f.dq_en = 1'b1; f.dqs_en = 1'b1; f.dqs_toggle = (state == ST_BURST);
          word_nxt = func_encode_cmd(col_addr, bank_r, RCW_WRITE, f, 1'b0);
        end else begin
          f.sel = RSEL; f.dci = 1'b1; f.buf_wr = 1'b1;
          word_nxt = func_encode_cmd(col_addr, bank_r, RCW_READ, f, 1'b0);
        end
      end
      ST_TAIL: begin
        f.odt = wr_mode; f.dq_en = wr_mode; f.dqs_en = wr_mode; f.dqs_toggle = wr_mode;
        f.dci = !wr_mode; f.buf_wr = !wr_mode;
        word_nxt = func_encode_skip(CMD_PAUSE_BITS, CMD_DONE_BIT, 15'd2, 1'b0, bank_r, f);
      end
      ST_PRE:   word_nxt = func_encode_cmd(15'd0, bank_r, RCW_PRECHARGE, f, 1'b0);
      ST_PREW:  word_nxt = func_encode_skip(CMD_PAUSE_BITS, CMD_DONE_BIT, 15'd2, 1'b0, bank_r, f);
      ST_FIN:   word_nxt = func_encode_skip(CMD_PAUSE_BITS, CMD_DONE_BIT, 15'd0, 1'b1, bank_r, f);
      default:  word_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cmd  <= '0;
      enc_wr   <= 1'b0;
      enc_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      enc_cmd  <= word_nxt;
      enc_wr   <= (state_nxt != ST_IDLE);
      enc_done <= (state == ST_FIN);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_cmd_encod_linear_rw.sv
// Scoreboard bench: stimulus pushes expected words/done cycles, a negedge monitor pops and compares.
module tb_cmd_encod_linear_rw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  bank_in;
  logic [14:0] row_in;
  logic [9:0]  start_col;
  logic [5:0]  num128_in;
  logic        start_rd, start_wr;
  logic [31:0] enc_cmd;
  logic        enc_wr, enc_done, busy;

  cmd_encod_linear_rw dut (
    .clk(clk), .rst_n(rst_n), .bank_in(bank_in), .row_in(row_in), .start_col(start_col),
    .num128_in(num128_in), .start_rd(start_rd), .start_wr(start_wr),
    .enc_cmd(enc_cmd), .enc_wr(enc_wr), .enc_done(enc_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] w; } exp_t;
  exp_t wq[$];
  int   dq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] mkw(input logic [14:0] a, input logic [2:0] b, input logic [2:0] rcw,
                                      input bit odt, input bit sel, input bit dqe, input bit dqse,
                                      input bit tog, input bit dci, input bit bw, input bit br, input bit nop);
    return {a, b, rcw, odt, 1'b0, sel, dqe, dqse, tog, dci, bw, br, nop, 1'b0};
  endfunction

  task automatic push(input int c, input logic [31:0] w);
    exp_t e;
    e.c = c; e.w = w;
    wq.push_back(e);
  endtask

  task automatic push_seq(input bit wr, input logic [2:0] b, input logic [14:0] row,
                          input logic [9:0] col, input int num, input int c0);
    int n;
    logic [9:0] cc;
    n = (num == 0) ? 64 : num;
    cc = {col[9:3], 3'b000};
    push(c0 + 1, mkw(row, b, 3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    push(c0 + 2, mkw(15'd1, b, 3'd0, 0, 0, 0, 0, 0, 0, 0, wr, 1));
    for (int k = 0; k < n; k++) begin
      if (wr) push(c0 + 3 + k, mkw({5'd0, cc}, b, 3'd3, 1, 1, 1, 1, k > 0, 0, 0, 1, 0));
      else    push(c0 + 3 + k, mkw({5'd0, cc}, b, 3'd2, 0, 1, 0, 0, 0, 1, 1, 0, 0));
      cc = cc + 10'd8;
    end
    push(c0 + n + 3, mkw(15'd2, b, 3'd0, wr, 0, wr, wr, wr, !wr, !wr, 0, 1));
    push(c0 + n + 4, mkw(15'd0, b, 3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(c0 + n + 5, mkw(15'd2, b, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    push(c0 + n + 6, mkw(15'h400, b, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    dq.push_back(c0 + n + 7);
  endtask

  // Called #1 after a posedge; returns start cycle, leaves us #1 into cycle c0+1
  task automatic do_start(input bit rd, input bit wr, input logic [2:0] b, input logic [14:0] row,
                          input logic [9:0] col, input logic [5:0] num, output int c0);
    bank_in = b; row_in = row; start_col = col; num128_in = num;
    start_rd = rd; start_wr = wr;
    c0 = cyc;
    @(posedge clk); #1;
    start_rd = 1'b0; start_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: got %0d words %0d dones pending want 0 0", wq.size(), dq.size());
    end
  endtask

  always @(negedge clk) begin
    if (enc_wr) begin
      if (wq.size() == 0) chk("unexpected_wr", enc_cmd, 32'hxxxx_xxxx);
      else begin
        exp_t e;
        e = wq.pop_front();
        chk("word_cycle", cyc, e.c);
        chk("word", enc_cmd, e.w);
      end
    end
    if (enc_done) begin
      if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0; bank_in = '0; row_in = '0; start_col = '0; num128_in = '0;
    start_rd = 1'b0; start_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enc_cmd", enc_cmd, 32'd0);
    chk("rst_enc_wr", {31'd0, enc_wr}, 32'd0);
    chk("rst_enc_done", {31'd0, enc_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // write bank 3 row 0x1234 col 0x010 N=1, hand-encoded words
    c0 = cyc;
    push(c0 + 1, 32'h2468_E002);
    push(c0 + 2, 32'h0002_C006);
    push(c0 + 3, 32'h0020_DDC4);
    push(c0 + 4, 32'h0004_C4E2);
    push(c0 + 5, 32'h0000_E800);
    push(c0 + 6, 32'h0004_C002);
    push(c0 + 7, 32'h0800_C002);
    dq.push_back(c0 + 8);
    do_start(1'b0, 1'b1, 3'd3, 15'h1234, 10'h010, 6'd1, c0);
    chk("busy_first", {31'd0, busy}, 32'd1);
    repeat (6) begin @(posedge clk); #1; end
    chk("busy_last_word", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    wait_idle(20);

    // read N=4 col 0x3F8 wraps; a start_wr at cycle 3 must be ignored
    push_seq(1'b0, 3'd5, 15'h0ABC, 10'h3F8, 4, cyc);
    do_start(1'b1, 1'b0, 3'd5, 15'h0ABC, 10'h3F8, 6'd4, c0);
    repeat (2) begin @(posedge clk); #1; end
    bank_in = 3'd1; row_in = 15'h7777; start_col = 10'h100; num128_in = 6'd2; start_wr = 1'b1;
    @(posedge clk); #1;
    start_wr = 1'b0;
    chk("busy_ignored_start", {31'd0, busy}, 32'd1);
    wait_idle(30);

    // start_rd and start_wr together: write wins; low column bits dropped
    push_seq(1'b1, 3'd2, 15'h7FFF, 10'h1FF, 2, cyc);
    do_start(1'b1, 1'b1, 3'd2, 15'h7FFF, 10'h1FF, 6'd2, c0);
    wait_idle(30);

    // num128_in=0 means 64 bursts
    push_seq(1'b1, 3'd7, 15'h0001, 10'h000, 0, cyc);
    do_start(1'b0, 1'b1, 3'd7, 15'h0001, 10'h000, 6'd0, c0);
    wait_idle(100);

    // reset during BURST k=2 of N=8: only ACT, GAP, B0, B1 may appear
    push_seq(1'b1, 3'd1, 15'h0222, 10'h040, 8, cyc);
    while (wq.size() > 4) void'(wq.pop_back());
    dq.delete();
    do_start(1'b0, 1'b1, 3'd1, 15'h0222, 10'h040, 6'd8, c0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_enc_wr", {31'd0, enc_wr}, 32'd0);
    chk("abort_enc_done", {31'd0, enc_done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_pending", wq.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean sequence after abort
    push_seq(1'b0, 3'd4, 15'h5555, 10'h123, 3, cyc);
    do_start(1'b1, 1'b0, 3'd4, 15'h5555, 10'h123, 6'd3, c0);
    wait_idle(30);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
